// File: rtl/sd_pkg.sv
// Shared types and constants for the SD read arbiter.
package sd_pkg;

    // Sequencer states; INIT_REQ is zero so the debug LEDs read 0 in reset.
    typedef enum logic [2:0] {
        INIT_REQ   = 3'd0,
        INIT_WAIT  = 3'd1,
        IDLE       = 3'd2,
        ISSUE      = 3'd3,
        WAIT       = 3'd4,
        IDLE_RETRY = 3'd5,
        RESP       = 3'd6
    } sd_state_t;

    // R1 response flags with no error bits set.
    localparam logic [7:0] R1_OK = 8'h00;

    // Block address as seen by the SD controller.
    typedef logic [31:0] blk_addr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first requester above the pointer, with wrap.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               valid
);

    // Scan ptr+1, ptr+2, ... wrapping, and keep the first set request.
    always_comb begin
        int pos;
        pos   = 0;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos = (int'(ptr) + k) % NUM_REQ;
            if (!valid && req[pos]) begin
                valid      = 1'b1;
                grant[pos] = 1'b1;
                idx        = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/sd_read_arbiter.sv
// Runs SD card init once, then shares the controller's block-read port among
// NUM_REQ requesters in round-robin order, with R1 retry and timeout recovery.
module sd_read_arbiter
    import sd_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*32-1:0] req_addr,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err,
    output logic                  ready,
    output logic                  ctrl_init_start,
    input  logic                  ctrl_init_done,
    output logic                  ctrl_read_start,
    input  logic                  ctrl_read_done,
    output logic [31:0]           ctrl_addr,
    input  logic [31:0]           ctrl_data,
    input  logic [7:0]            ctrl_flags,
    output logic [2:0]            state_dbg
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
    localparam logic [IW-1:0] RR_INIT   = IW'(NUM_REQ - 1);

    sd_state_t    state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic [IW-1:0] rr, rr_nx;
    logic [RW-1:0] retry, retry_nx;
    logic          timed_out, timed_out_nx;

    logic [NUM_REQ-1:0] gnt_nx, rsp_valid_nx;
    logic [31:0]        rsp_data_nx;
    logic               rsp_err_nx, ready_nx, init_start_nx, read_start_nx;
    blk_addr_t          addr_nx, sel_addr;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               arb_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr_arbiter (
        .req   (req),
        .ptr   (rr),
        .grant (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    assign state_dbg = state;

    // Pick the winning requester's address out of the flat address bus.
    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) sel_addr = req_addr[32*i +: 32];
        end
    end

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_nx      = state;
        timer_nx      = (timer == TIMER_MAX) ? timer : timer + 1'b1;
        rr_nx         = rr;
        retry_nx      = retry;
        timed_out_nx  = timed_out;
        gnt_nx        = gnt;
        rsp_valid_nx  = '0;
        rsp_data_nx   = rsp_data;
        rsp_err_nx    = rsp_err;
        ready_nx      = ready;
        init_start_nx = ctrl_init_start;
        read_start_nx = ctrl_read_start;
        addr_nx       = ctrl_addr;

        case (state)
            INIT_REQ: begin
                init_start_nx = 1'b1;
                ready_nx      = 1'b0;
                timer_nx      = '0;
                state_nx      = INIT_WAIT;
            end
            INIT_WAIT: begin
                init_start_nx = 1'b1;
                if (ctrl_init_done) begin
                    init_start_nx = 1'b0;
                    ready_nx      = 1'b1;
                    state_nx      = IDLE;
                end else if (timer == TIMER_MAX) begin
                    state_nx = INIT_REQ;
                end
            end
            IDLE: begin
                ready_nx = 1'b1;
                if (!ctrl_read_done && arb_valid) begin
                    addr_nx  = sel_addr;
                    gnt_nx   = arb_gnt;
                    rr_nx    = arb_idx;
                    retry_nx = '0;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                read_start_nx = 1'b1;
                timer_nx      = '0;
                state_nx      = WAIT;
            end
            WAIT: begin
                read_start_nx = 1'b1;
                if (ctrl_read_done) begin
                    read_start_nx = 1'b0;
                    rsp_data_nx   = ctrl_data;
                    if (ctrl_flags == R1_OK) begin
                        rsp_valid_nx = gnt;
                        rsp_err_nx   = 1'b0;
                        gnt_nx       = '0;
                        state_nx     = RESP;
                    end else if (retry < RETRY_MAX) begin
                        retry_nx = retry + 1'b1;
                        state_nx = IDLE_RETRY;
                    end else begin
                        rsp_valid_nx = gnt;
                        rsp_err_nx   = 1'b1;
                        gnt_nx       = '0;
                        state_nx     = RESP;
                    end
                end else if (timer == TIMER_MAX) begin
                    read_start_nx = 1'b0;
                    rsp_valid_nx  = gnt;
                    rsp_err_nx    = 1'b1;
                    gnt_nx        = '0;
                    ready_nx      = 1'b0;
                    timed_out_nx  = 1'b1;
                    state_nx      = RESP;
                end
            end
            IDLE_RETRY: begin
                if (!ctrl_read_done) state_nx = ISSUE;
            end
            RESP: begin
                timed_out_nx = 1'b0;
                state_nx     = timed_out ? INIT_REQ : IDLE;
            end
            default: begin
                state_nx = INIT_REQ;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= INIT_REQ;
            timer           <= '0;
            rr              <= RR_INIT;
            retry           <= '0;
            timed_out       <= 1'b0;
            gnt             <= '0;
            rsp_valid       <= '0;
            rsp_data        <= '0;
            rsp_err         <= 1'b0;
            ready           <= 1'b0;
            ctrl_init_start <= 1'b0;
            ctrl_read_start <= 1'b0;
            ctrl_addr       <= '0;
        end else begin
            state           <= state_nx;
            timer           <= timer_nx;
            rr              <= rr_nx;
            retry           <= retry_nx;
            timed_out       <= timed_out_nx;
            gnt             <= gnt_nx;
            rsp_valid       <= rsp_valid_nx;
            rsp_data        <= rsp_data_nx;
            rsp_err         <= rsp_err_nx;
            ready           <= ready_nx;
            ctrl_init_start <= init_start_nx;
            ctrl_read_start <= read_start_nx;
            ctrl_addr       <= addr_nx;
        end
    end

endmodule

// File: tb/tb_sd_read_arbiter.sv
// Directed bench for sd_read_arbiter with a hand-driven SD controller.
module tb_sd_read_arbiter;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic [3:0]   req = '0;
    logic [127:0] req_addr = '0;
    logic [3:0]   gnt, rsp_valid;
    logic [31:0]  rsp_data, ctrl_addr;
    logic         rsp_err, ready, ctrl_init_start, ctrl_read_start;
    logic         ctrl_init_done = 1'b0;
    logic         ctrl_read_done = 1'b0;
    logic [31:0]  ctrl_data = '0;
    logic [7:0]   ctrl_flags = '0;
    logic [2:0]   state_dbg;

    int errors = 0;
    int checks = 0;

    sd_read_arbiter #(
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (100),
        .MAX_RETRIES    (3)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req             (req),
        .req_addr        (req_addr),
        .gnt             (gnt),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .rsp_err         (rsp_err),
        .ready           (ready),
        .ctrl_init_start (ctrl_init_start),
        .ctrl_init_done  (ctrl_init_done),
        .ctrl_read_start (ctrl_read_start),
        .ctrl_read_done  (ctrl_read_done),
        .ctrl_addr       (ctrl_addr),
        .ctrl_data       (ctrl_data),
        .ctrl_flags      (ctrl_flags),
        .state_dbg       (state_dbg)
    );

    always #5 clk = ~clk;

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Acts as the controller for one read: waits for read_start, returns
    // flags/data after a latency, and reports grant/address seen at issue.
    task automatic serve_read(input logic [7:0] flags, input logic [31:0] data,
                              input int latency, output logic ok,
                              output logic [3:0] g, output logic [31:0] a);
        ok = 1'b0;
        g  = '0;
        a  = '0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (ctrl_read_start) ok = 1'b1;
        end
        if (!ok) return;
        g = gnt;
        a = ctrl_addr;
        repeat (latency) @(negedge clk);
        ctrl_flags     = flags;
        ctrl_data      = data;
        ctrl_read_done = 1'b1;
        @(negedge clk);
        ctrl_read_done = 1'b0;
        ctrl_flags     = '0;
        ctrl_data      = '0;
    endtask

    task automatic test_reset();
        reset_n  = 1'b1;
        #1 reset_n = 1'b0;
        req      = 4'b0101;
        req_addr[31:0]  = 32'h200;
        req_addr[95:64] = 32'h400;
        repeat (2) @(negedge clk);
        checks++;
        if ({gnt, rsp_valid, ready, ctrl_init_start, ctrl_read_start, state_dbg} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got gnt=%b rv=%b rdy=%b is=%b rs=%b st=%0d, expected all 0",
                     gnt, rsp_valid, ready, ctrl_init_start, ctrl_read_start, state_dbg);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl_init_start !== 1'b1 || state_dbg !== 3'd1) begin
            errors++;
            $display("[TB] FAIL init_start_c1: got is=%b st=%0d, expected is=1 st=1",
                     ctrl_init_start, state_dbg);
        end
        for (int c = 2; c <= 11; c++) begin
            @(negedge clk);
            checks++;
            if (gnt !== 4'b0 || ready !== 1'b0 || ctrl_init_start !== 1'b1) begin
                errors++;
                $display("[TB] FAIL init_hold_c%0d: got gnt=%b rdy=%b is=%b, expected 0000/0/1",
                         c, gnt, ready, ctrl_init_start);
            end
        end
        ctrl_init_done = 1'b1;
        @(negedge clk);
        ctrl_init_done = 1'b0;
        checks++;
        if (ready !== 1'b1 || ctrl_init_start !== 1'b0 || gnt !== 4'b0 || state_dbg !== 3'd2) begin
            errors++;
            $display("[TB] FAIL ready_c12: got rdy=%b is=%b gnt=%b st=%0d, expected 1/0/0000/2",
                     ready, ctrl_init_start, gnt, state_dbg);
        end
    endtask

    task automatic test_round_robin();
        logic        ok;
        logic [3:0]  g, exp_g;
        logic [31:0] a, exp_a, d;
        for (int n = 0; n < 4; n++) begin
            exp_g = (n % 2 == 0) ? 4'b0001 : 4'b0100;
            exp_a = (n % 2 == 0) ? 32'h200 : 32'h400;
            d     = 32'hA000_0000 + n;
            serve_read(8'h00, d, 2, ok, g, a);
            if (n == 3) req = 4'b0000;
            checks++;
            if (!ok || g !== exp_g || a !== exp_a) begin
                errors++;
                $display("[TB] FAIL rr_grant_%0d: got ok=%b gnt=%b addr=%h, expected gnt=%b addr=%h",
                         n, ok, g, a, exp_g, exp_a);
            end
            checks++;
            if (rsp_valid !== exp_g || rsp_err !== 1'b0 || rsp_data !== d || gnt !== 4'b0) begin
                errors++;
                $display("[TB] FAIL rr_resp_%0d: got rv=%b err=%b data=%h gnt=%b, expected rv=%b err=0 data=%h gnt=0000",
                         n, rsp_valid, rsp_err, rsp_data, gnt, exp_g, d);
            end
        end
    endtask

    task automatic test_retry_success();
        logic        ok;
        logic [3:0]  g;
        logic [31:0] a;
        req_addr[63:32] = 32'h600;
        req = 4'b0010;
        for (int n = 0; n < 3; n++) begin
            serve_read((n < 2) ? 8'h04 : 8'h00, 32'hCAFE_0001, 1, ok, g, a);
            if (n == 0) req_addr[63:32] = 32'hDEAD_BEEF;
            checks++;
            if (!ok || g !== 4'b0010 || a !== 32'h600) begin
                errors++;
                $display("[TB] FAIL retry_issue_%0d: got ok=%b gnt=%b addr=%h, expected gnt=0010 addr=600",
                         n, ok, g, a);
            end
            if (n < 2) begin
                checks++;
                if (rsp_valid !== 4'b0 || gnt !== 4'b0010) begin
                    errors++;
                    $display("[TB] FAIL retry_nores_%0d: got rv=%b gnt=%b, expected rv=0000 gnt=0010",
                             n, rsp_valid, gnt);
                end
            end
        end
        req = 4'b0000;
        checks++;
        if (rsp_valid !== 4'b0010 || rsp_err !== 1'b0 || rsp_data !== 32'hCAFE_0001) begin
            errors++;
            $display("[TB] FAIL retry_resp: got rv=%b err=%b data=%h, expected rv=0010 err=0 data=cafe0001",
                     rsp_valid, rsp_err, rsp_data);
        end
    endtask

    task automatic test_retry_exhausted();
        logic        ok;
        logic [3:0]  g;
        logic [31:0] a;
        int          issues = 0;
        req_addr[127:96] = 32'h800;
        req = 4'b1000;
        for (int n = 0; n < 4; n++) begin
            serve_read(8'h05, 32'h1111_0000 + n, 1, ok, g, a);
            if (ok && g === 4'b1000) issues++;
            if (n == 0) req = 4'b0000;
            if (n < 3) begin
                checks++;
                if (rsp_valid !== 4'b0) begin
                    errors++;
                    $display("[TB] FAIL exhaust_early_%0d: got rv=%b, expected 0000", n, rsp_valid);
                end
            end
        end
        checks++;
        if (issues != 4 || rsp_valid !== 4'b1000 || rsp_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL exhaust_resp: got issues=%0d rv=%b err=%b, expected 4/1000/1",
                     issues, rsp_valid, rsp_err);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (ctrl_read_start !== 1'b0 || state_dbg !== 3'd2 || ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL exhaust_idle_%0d: got rs=%b st=%0d rdy=%b, expected 0/2/1",
                         c, ctrl_read_start, state_dbg, ready);
            end
        end
    endtask

    task automatic test_timeout();
        logic seen = 1'b0;
        int   n = 0;
        req = 4'b0001;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ctrl_read_start) seen = 1'b1;
        end
        while (seen && rsp_valid === 4'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        req = 4'b0000;
        checks++;
        if (!seen || n != 101) begin
            errors++;
            $display("[TB] FAIL timeout_cycles: got seen=%b cycles=%0d, expected 101", seen, n);
        end
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_err !== 1'b1 || ready !== 1'b0 || gnt !== 4'b0) begin
            errors++;
            $display("[TB] FAIL timeout_resp: got rv=%b err=%b rdy=%b gnt=%b, expected 0001/1/0/0000",
                     rsp_valid, rsp_err, ready, gnt);
        end
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            if (ctrl_init_start) seen = 1'b1;
        end
        checks++;
        if (!seen || ready !== 1'b0 || state_dbg !== 3'd1) begin
            errors++;
            $display("[TB] FAIL timeout_reinit: got is_seen=%b rdy=%b st=%0d, expected 1/0/1",
                     seen, ready, state_dbg);
        end
        ctrl_init_done = 1'b1;
        @(negedge clk);
        ctrl_init_done = 1'b0;
        checks++;
        if (ready !== 1'b1 || ctrl_init_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_ready: got rdy=%b is=%b, expected 1/0", ready, ctrl_init_start);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic seen = 1'b0;
        req = 4'b0100;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ctrl_read_start) seen = 1'b1;
        end
        checks++;
        if (!seen || gnt !== 4'b0100 || ctrl_addr !== 32'h400) begin
            errors++;
            $display("[TB] FAIL midreset_issue: got seen=%b gnt=%b addr=%h, expected 1/0100/400",
                     seen, gnt, ctrl_addr);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({gnt, rsp_valid, rsp_err, ready, ctrl_init_start, ctrl_read_start, state_dbg} !== '0
            || ctrl_addr !== 32'h0 || rsp_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL midreset_async: got gnt=%b rs=%b rdy=%b st=%0d addr=%h, expected all 0",
                     gnt, ctrl_read_start, ready, state_dbg, ctrl_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        req     = 4'b0000;
        @(negedge clk);
        checks++;
        if (ctrl_init_start !== 1'b1 || ready !== 1'b0 || state_dbg !== 3'd1) begin
            errors++;
            $display("[TB] FAIL midreset_restart: got is=%b rdy=%b st=%0d, expected 1/0/1",
                     ctrl_init_start, ready, state_dbg);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_retry_success();
        test_retry_exhausted();
        test_timeout();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sd_read_arbiter.md
Name: sd_read_arbiter

Overview:
- Sequences the SD card controller and shares its single block-read port among NUM_REQ requesters, for example a sprite loader, an audio streamer and a debug port.
- After reset it runs card initialisation once, then serves read requests in round-robin order, one at a time.
- Checks the R1 flags on every read, retries on failure and recovers from a hung controller with a timeout followed by re-initialisation.
- Sits between the client logic and sd_controller, in the SD_CLK domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 65535, clk cycles allowed per init or read before abort
MAX_RETRIES, 3, re-issues of a read whose R1 flags are nonzero

Ports:
clk  in  1  SD clock domain (SD_CLK)
reset_n  in  1  asynchronous reset, active-low
req  in  NUM_REQ  per-requester read request, level
req_addr  in  NUM_REQ*32  per-requester block address; requester i uses bits [32i+31:32i]
gnt  out  NUM_REQ  one-hot; high while requester i's read is in flight
rsp_valid  out  NUM_REQ  one-cycle pulse to the granted requester on completion
rsp_data  out  32  read data, valid while any rsp_valid bit is high
rsp_err  out  1  qualifies rsp_valid: 1 = read failed (retries exhausted or timeout)
ready  out  1  init complete and arbiter accepting requests
ctrl_init_start  out  1  to sd_controller init_start
ctrl_init_done  in  1  from sd_controller init_done
ctrl_read_start  out  1  to sd_controller read_start
ctrl_read_done  in  1  from sd_controller read_done
ctrl_addr  out  32  to sd_controller addr
ctrl_data  in  32  from sd_controller response_data
ctrl_flags  in  8  from sd_controller response_flags (R1)
state_dbg  out  3  current FSM state encoding, for LEDs

Behaviour:
- Reset (async assert, sync release): all outputs 0; FSM in INIT_REQ; rr pointer = NUM_REQ-1; retry count 0; timer 0.
- INIT_REQ: drive ctrl_init_start=1, clear timer, go to INIT_WAIT.
- INIT_WAIT: hold ctrl_init_start=1.
  - If ctrl_init_done=1: drop init_start and go to IDLE; ready rises the cycle after.
  - If timer reaches TIMEOUT_CYCLES: go to INIT_REQ. Init retries forever; ready stays 0.
- IDLE:
  - ready=1.
  - If ctrl_read_done=1 (left over from the previous read), stay in IDLE.
  - Otherwise, if any req bit is set, pick the first set bit searching from rr+1 upward with wrap.
  - Latch that requester's address into ctrl_addr, set its gnt bit, set rr to its index, clear retry count, go to ISSUE.
  - Arbitration decision to gnt high: 1 cycle.
- ISSUE: ctrl_read_start=1, clear timer, go to WAIT.
- WAIT: hold ctrl_read_start=1 until ctrl_read_done=1, then drop it.
  - ctrl_flags==0: go to RESP with err=0 and rsp_data=ctrl_data.
  - ctrl_flags!=0 and retry<MAX_RETRIES: increment retry, go to IDLE_RETRY. IDLE_RETRY waits for read_done=0, then goes to ISSUE; gnt stays held.
  - ctrl_flags!=0 and retries exhausted: go to RESP with err=1.
  - Timer reaches TIMEOUT_CYCLES: go to RESP with err=1, then INIT_REQ instead of IDLE. ready=0 during re-init.
- RESP: pulse rsp_valid[granted]=1 with rsp_err, clear gnt the same cycle, go to IDLE (or INIT_REQ after a timeout).
  - rsp_data holds its value until the next RESP.
- ctrl_addr is stable from ISSUE through the end of WAIT. A requester changing req_addr mid-transaction has no effect.
- Requester drops req after grant: the transaction still completes and rsp_valid still pulses.
- Requests arriving while not in IDLE wait. Requests are never dropped or queued beyond the level req.
- The timer saturates and never wraps.
- NUM_REQ=1 degenerates to a pass-through with retry and timeout.

Decomposition:
- Package sd_pkg holds:
  - state enum (INIT_REQ, INIT_WAIT, IDLE, ISSUE, WAIT, IDLE_RETRY, RESP), 3 bits
  - R1_OK constant = 8'h00
  - a typedef for the 32-bit block address
- One sub-module, rr_arbiter: combinational round-robin priority select with inputs req and rr pointer, outputs one-hot grant and index.

Test Plan:
- Reset, then init_done asserted 10 cycles after init_start -> ready=1 on cycle 12; no gnt before ready.
- req=4'b0101 continuously, every read returns flags=0 -> grant order 0,2,0,2; ctrl_addr matches each requester's req_addr (e.g. 0x200, 0x400).
- Requester 1 reads addr 0x600, flags=8'h04 on the first two attempts and 8'h00 on the third -> three read_start pulses; rsp_valid[1] with rsp_err=0 and data=ctrl_data.
- Flags=8'h05 on all attempts -> 4 issues total (1 + MAX_RETRIES), then rsp_valid with rsp_err=1, return to IDLE.
- read_done never arrives, with TIMEOUT_CYCLES=100 -> rsp_err=1 at cycle 101 of WAIT, ready=0, init_start reasserted.
- reset_n asserted mid-WAIT -> all outputs 0 asynchronously; after release, init sequence restarts.
